// File: rtl/stereo_matrix_top.sv
// Stereo de-matrix: left = LPR + LMR, right = LPR - LMR through a 2-stage stall-able pipeline.
// Optional build macro SATURATE_EN clamps overflowed results; otherwise they wrap.

module stereo_matrix_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells full apart from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module stereo_matrix_top #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] lpr_in_din,
  input  logic                 lpr_in_wr_en,
  output logic                 lpr_in_full,
  input  logic [DATA_SIZE-1:0] lmr_in_din,
  input  logic                 lmr_in_wr_en,
  output logic                 lmr_in_full,
  input  logic                 mono_mode,
  output logic [DATA_SIZE-1:0] left_out_dout,
  output logic                 left_out_empty,
  input  logic                 left_out_rd_en,
  output logic [DATA_SIZE-1:0] right_out_dout,
  output logic                 right_out_empty,
  input  logic                 right_out_rd_en,
  output logic [CNT_WIDTH-1:0] overflow_count
);
  localparam logic [DATA_SIZE-1:0] SMAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SMIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  logic [DATA_SIZE-1:0] lpr_head, lmr_head;
  logic                 lpr_empty, lmr_empty;
  logic                 left_full, right_full;

  logic [DATA_SIZE-1:0] lpr_r, lmr_r;
  logic                 mono_r, v1;
  logic [DATA_SIZE-1:0] left_r, right_r;
  logic                 ovf_r, v2;

  logic                 out_go, s2_load, s1_load;
  logic [DATA_SIZE:0]   sum_ext, diff_ext;
  logic                 left_ovf, right_ovf;
  logic [DATA_SIZE-1:0] left_val, right_val;

  assign out_go  = v2 & ~left_full & ~right_full;
  assign s2_load = v1 & (~v2 | out_go);
  assign s1_load = ~lpr_empty & ~lmr_empty & (~v1 | s2_load);

  stereo_matrix_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_lpr_fifo (
    .clock(clock), .reset(reset), .din(lpr_in_din), .wr_en(lpr_in_wr_en), .full(lpr_in_full),
    .dout(lpr_head), .rd_en(s1_load), .empty(lpr_empty)
  );

  stereo_matrix_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_lmr_fifo (
    .clock(clock), .reset(reset), .din(lmr_in_din), .wr_en(lmr_in_wr_en), .full(lmr_in_full),
    .dout(lmr_head), .rd_en(s1_load), .empty(lmr_empty)
  );

  stereo_matrix_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_left_fifo (
    .clock(clock), .reset(reset), .din(left_r), .wr_en(out_go), .full(left_full),
    .dout(left_out_dout), .rd_en(left_out_rd_en), .empty(left_out_empty)
  );

  stereo_matrix_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_right_fifo (
    .clock(clock), .reset(reset), .din(right_r), .wr_en(out_go), .full(right_full),
    .dout(right_out_dout), .rd_en(right_out_rd_en), .empty(right_out_empty)
  );

  // One guard bit: overflow whenever the top two result bits disagree.
  always_comb begin
    sum_ext   = {lpr_r[DATA_SIZE-1], lpr_r} + {lmr_r[DATA_SIZE-1], lmr_r};
    diff_ext  = {lpr_r[DATA_SIZE-1], lpr_r} - {lmr_r[DATA_SIZE-1], lmr_r};
    left_ovf  = 1'b0;
    right_ovf = 1'b0;
    left_val  = sum_ext[DATA_SIZE-1:0];
    right_val = diff_ext[DATA_SIZE-1:0];
    if (mono_r) begin
      left_val  = lpr_r;
      right_val = lpr_r;
    end else begin
      left_ovf  = sum_ext[DATA_SIZE]  != sum_ext[DATA_SIZE-1];
      right_ovf = diff_ext[DATA_SIZE] != diff_ext[DATA_SIZE-1];
`ifdef SATURATE_EN
      if (left_ovf)  left_val  = sum_ext[DATA_SIZE]  ? SMIN : SMAX;
      if (right_ovf) right_val = diff_ext[DATA_SIZE] ? SMIN : SMAX;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1     <= 1'b0;
      lpr_r  <= '0;
      lmr_r  <= '0;
      mono_r <= 1'b0;
    end else if (s1_load) begin
      v1     <= 1'b1;
      lpr_r  <= lpr_head;
      lmr_r  <= lmr_head;
      mono_r <= mono_mode;
    end else if (s2_load) begin
      v1     <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v2      <= 1'b0;
      left_r  <= '0;
      right_r <= '0;
      ovf_r   <= 1'b0;
    end else if (s2_load) begin
      v2      <= 1'b1;
      left_r  <= left_val;
      right_r <= right_val;
      ovf_r   <= left_ovf | right_ovf;
    end else if (out_go) begin
      v2      <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (out_go && ovf_r && (overflow_count != {CNT_WIDTH{1'b1}})) begin
      overflow_count <= overflow_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_stereo_matrix_top.sv
// Scoreboard bench for stereo_matrix_top: stimulus pushes expected left/right, a monitor pops and compares on every read.
module tb_stereo_matrix_top;
  logic        clock;
  logic        reset;
  logic [31:0] lpr_in_din, lmr_in_din;
  logic        lpr_in_wr_en, lmr_in_wr_en;
  logic        lpr_in_full, lmr_in_full;
  logic        mono_mode;
  logic [31:0] left_out_dout, right_out_dout;
  logic        left_out_empty, right_out_empty;
  logic        left_out_rd_en, right_out_rd_en;
  logic [15:0] overflow_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] left_q[$];
  logic [31:0] right_q[$];
  bit left_read_on = 0;
  bit right_read_on = 0;
  int accepted;

  stereo_matrix_top dut (
    .clock(clock), .reset(reset),
    .lpr_in_din(lpr_in_din), .lpr_in_wr_en(lpr_in_wr_en), .lpr_in_full(lpr_in_full),
    .lmr_in_din(lmr_in_din), .lmr_in_wr_en(lmr_in_wr_en), .lmr_in_full(lmr_in_full),
    .mono_mode(mono_mode),
    .left_out_dout(left_out_dout), .left_out_empty(left_out_empty), .left_out_rd_en(left_out_rd_en),
    .right_out_dout(right_out_dout), .right_out_empty(right_out_empty), .right_out_rd_en(right_out_rd_en),
    .overflow_count(overflow_count)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the head against the scoreboard, then pop it on the next edge.
  initial begin
    logic [31:0] e;
    left_out_rd_en = 0;
    right_out_rd_en = 0;
    forever begin
      @(negedge clock);
      if (left_read_on && !left_out_empty && !reset) begin
        if (left_q.size() == 0) chk("left_unexpected", left_out_dout, 32'hx);
        else begin e = left_q.pop_front(); chk("left_data", left_out_dout, e); end
        left_out_rd_en = 1;
      end else left_out_rd_en = 0;
      if (right_read_on && !right_out_empty && !reset) begin
        if (right_q.size() == 0) chk("right_unexpected", right_out_dout, 32'hx);
        else begin e = right_q.pop_front(); chk("right_data", right_out_dout, e); end
        right_out_rd_en = 1;
      end else right_out_rd_en = 0;
    end
  end

  task automatic write_pair(input logic [31:0] l, input logic [31:0] m, input logic [31:0] el, input logic [31:0] er);
    @(negedge clock);
    lpr_in_din = l; lmr_in_din = m;
    lpr_in_wr_en = 1; lmr_in_wr_en = 1;
    left_q.push_back(el); right_q.push_back(er);
    @(negedge clock);
    lpr_in_wr_en = 0; lmr_in_wr_en = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    left_read_on = 1; right_read_on = 1;
    while ((left_q.size() != 0 || right_q.size() != 0) && n < 300) begin
      @(negedge clock); n++;
    end
    if (n >= 300) chk({name, "_drain_timeout"}, left_q.size() + right_q.size(), 0);
    repeat (4) @(negedge clock);
    chk({name, "_left_empty"}, left_out_empty, 1);
    chk({name, "_right_empty"}, right_out_empty, 1);
  endtask

  initial begin
    reset = 1; mono_mode = 0;
    lpr_in_din = 0; lmr_in_din = 0; lpr_in_wr_en = 0; lmr_in_wr_en = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_left_empty", left_out_empty, 1);
    chk("rst_right_empty", right_out_empty, 1);
    chk("rst_lpr_full", lpr_in_full, 0);
    chk("rst_lmr_full", lmr_in_full, 0);
    chk("rst_ovf_count", overflow_count, 0);

    // Stereo basic: empties must drop in the same cycle.
    write_pair(100, 30, 130, 70);
    repeat (5) begin
      @(negedge clock);
      chk("basic_empty_together", left_out_empty, right_out_empty);
    end
    chk("basic_left_present", left_out_empty, 0);
    drain("basic");
    chk("basic_ovf_count", overflow_count, 0);

    // Positive overflow on left only.
`ifdef SATURATE_EN
    write_pair(32'h7FFFFFF0, 32'h20, 32'h7FFFFFFF, 32'h7FFFFFD0);
`else
    write_pair(32'h7FFFFFF0, 32'h20, 32'h80000010, 32'h7FFFFFD0);
`endif
    drain("ovf");
    chk("ovf_count", overflow_count, 1);

    // Mono switch between the 2nd and 3rd pop.
    write_pair(1, 5, 6, 32'hFFFFFFFC);
    write_pair(2, 5, 7, 32'hFFFFFFFD);
    drain("mono_a");
    mono_mode = 1;
    write_pair(3, 5, 3, 3);
    write_pair(4, 5, 4, 4);
    drain("mono_b");
    mono_mode = 0;
    chk("mono_ovf_count", overflow_count, 1);

    // Backpressure: nothing is read; 16 out + 2 in pipeline + 16 in = 34 accepted.
    left_read_on = 0; right_read_on = 0;
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (lpr_in_full || lmr_in_full) break;
      lpr_in_din = 32'(i * 3); lmr_in_din = 32'(i);
      lpr_in_wr_en = 1; lmr_in_wr_en = 1;
      left_q.push_back(32'(i * 4)); right_q.push_back(32'(i * 2));
      accepted++;
      @(negedge clock);
      lpr_in_wr_en = 0; lmr_in_wr_en = 0;
    end
    repeat (5) @(negedge clock);
    chk("bp_accepted", accepted, 34);
    chk("bp_lpr_full", lpr_in_full, 1);
    chk("bp_lmr_full", lmr_in_full, 1);
    chk("bp_right_nonempty", right_out_empty, 0);
    chk("bp_left_nonempty", left_out_empty, 0);
    drain("bp");
    chk("bp_lpr_free", lpr_in_full, 0);

    // Skew: LPR alone must not pop.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      lpr_in_din = 32'(1000 + i); lpr_in_wr_en = 1;
      @(negedge clock);
      lpr_in_wr_en = 0;
    end
    repeat (10) @(negedge clock);
    chk("skew_left_empty", left_out_empty, 1);
    chk("skew_right_empty", right_out_empty, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      lmr_in_din = 32'(i * 7); lmr_in_wr_en = 1;
      left_q.push_back(32'(1000 + i + i * 7)); right_q.push_back(32'(1000 + i - i * 7));
      @(negedge clock);
      lmr_in_wr_en = 0;
    end
    drain("skew");

    // Reset with three pairs in flight; overflow_count is 1 beforehand.
    left_read_on = 0; right_read_on = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      lpr_in_din = 32'(50 + i); lmr_in_din = 1;
      lpr_in_wr_en = 1; lmr_in_wr_en = 1;
    end
    @(negedge clock);
    lpr_in_wr_en = 0; lmr_in_wr_en = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    left_q.delete(); right_q.delete();
    chk("rst2_left_empty", left_out_empty, 1);
    chk("rst2_right_empty", right_out_empty, 1);
    chk("rst2_ovf_count", overflow_count, 0);
    chk("rst2_lpr_full", lpr_in_full, 0);
    repeat (4) @(negedge clock);
    chk("rst2_stays_empty", left_out_empty, 1);
    write_pair(32'hFFFFFFF6, 3, 32'hFFFFFFF9, 32'hFFFFFFF3);
    write_pair(32'h80000000, 1, 32'h80000001, `ifdef SATURATE_EN 32'h80000000 `else 32'h7FFFFFFF `endif);
    drain("post_rst");
    chk("post_rst_ovf_count", overflow_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
